// File: rtl/scic_io_port.sv
// scic_io_port: memory-mapped switch/LED peripheral for the SCIC data bus.
// Switches pass through a two-flop synchroniser and a per-bit debouncer.
// Debounced edges latch sticky change flags that drive a maskable interrupt.
module scic_io_port #(
  parameter int SW_WIDTH        = 4,
  parameter int LED_WIDTH       = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SW_WIDTH-1:0]   switches,
  output logic [LED_WIDTH-1:0]  LEDs,
  input  logic [1:0]            addr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_valid,
  output logic                  irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_SW   = 2'd0,
    REG_LED  = 2'd1,
    REG_CHG  = 2'd2,
    REG_MASK = 2'd3
  } reg_sel_e;

  reg_sel_e              sel;
  logic [SW_WIDTH-1:0]   sync1;
  logic [SW_WIDTH-1:0]   sync2;
  logic [SW_WIDTH-1:0]   deb;
  logic [SW_WIDTH-1:0]   deb_edge;
  logic [SW_WIDTH-1:0]   chg;
  logic [SW_WIDTH-1:0]   chg_clr;
  logic [SW_WIDTH-1:0]   mask;
  logic [CNT_W-1:0]      cnt [SW_WIDTH];
  logic [LED_WIDTH-1:0]  led_q;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_wdata;

  assign sel  = reg_sel_e'(addr);
  assign LEDs = led_q;

  // Upper write-data bits beyond the register widths are intentionally dropped.
  assign unused_wdata = ^wdata;

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
    end
  end

  // A bit is accepted on the sample where its mismatch count would reach DEBOUNCE_CYCLES.
  always_comb begin
    deb_edge = '0;
    for (int unsigned i = 0; i < SW_WIDTH; i++) begin
      deb_edge[i] = (sync2[i] != deb[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Per-bit debouncer: any sample equal to the accepted level restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb <= '0;
      for (int unsigned i = 0; i < SW_WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < SW_WIDTH; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (deb_edge[i]) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Write-1-to-clear mask for the change flags.
  always_comb begin
    chg_clr = '0;
    if (wr_en && (sel == REG_CHG)) begin
      chg_clr = wdata[SW_WIDTH-1:0];
    end
  end

  // Read mux over current register values, zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_SW:   rd_mux[SW_WIDTH-1:0]  = deb;
      REG_LED:  rd_mux[LED_WIDTH-1:0] = led_q;
      REG_CHG:  rd_mux[SW_WIDTH-1:0]  = chg;
      REG_MASK: rd_mux[SW_WIDTH-1:0]  = mask;
      default:  rd_mux = '0;
    endcase
  end

  // Register file, sticky change flags (set beats clear), interrupt and read port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q    <= '0;
      mask     <= '0;
      chg      <= '0;
      irq      <= 1'b0;
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en && (sel == REG_LED)) begin
        led_q <= wdata[LED_WIDTH-1:0];
      end
      if (wr_en && (sel == REG_MASK)) begin
        mask <= wdata[SW_WIDTH-1:0];
      end
      chg      <= (chg & ~chg_clr) | deb_edge;
      irq      <= |(chg & mask);
      rd_valid <= rd_en;
      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_scic_io_port.sv
// Directed self-checking bench for scic_io_port with default parameters.
module tb_scic_io_port;

  logic        clock;
  logic        reset;
  logic [3:0]  switches;
  logic [3:0]  LEDs;
  logic [1:0]  addr;
  logic        wr_en;
  logic [31:0] wdata;
  logic        rd_en;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        irq;

  int tests;
  int fails;

  scic_io_port #(
    .SW_WIDTH(4),
    .LED_WIDTH(4),
    .DATA_WIDTH(32),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .switches(switches),
    .LEDs(LEDs),
    .addr(addr),
    .wr_en(wr_en),
    .wdata(wdata),
    .rd_en(rd_en),
    .rdata(rdata),
    .rd_valid(rd_valid),
    .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk(tag, rdata, exp);
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    switches = 4'b0000;
    addr     = 2'd0;
    wr_en    = 1'b0;
    wdata    = 32'd0;
    rd_en    = 1'b0;

    // Reset values while reset is held.
    #20;
    chk("rst_leds", {28'd0, LEDs}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    #7;
    reset = 1'b0;
    tick();

    rd(2'd0, 32'd0, "rst_sw");
    rd(2'd1, 32'd0, "rst_led");
    rd(2'd2, 32'd0, "rst_chg");
    rd(2'd3, 32'd0, "rst_mask");
    tick();
    chk("rd_valid_one_shot", {31'd0, rd_valid}, 32'd0);

    // Debounce accept: back-to-back reads of SW pin the accept edge.
    switches = 4'b0101;
    addr     = 2'd0;
    rd_en    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("b2b_valid", {31'd0, rd_valid}, 32'd1);
    end
    tick();
    chk("sw_before_accept", rdata, 32'd0);
    tick();
    chk("sw_accept", rdata, 32'd5);
    rd_en = 1'b0;
    rd(2'd2, 32'd5, "chg_accept");
    chk("irq_masked", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'hF);
    rd(2'd2, 32'd0, "chg_w1c");

    switches = 4'b0000;
    wait_ticks(8);
    wr(2'd2, 32'hF);
    rd(2'd0, 32'd0, "sw_back_low");
    rd(2'd2, 32'd0, "chg_cleared");

    // Glitch reject: 3-clock pulse on bit 0.
    switches = 4'b0001;
    wait_ticks(3);
    switches = 4'b0000;
    wait_ticks(8);
    rd(2'd0, 32'd0, "glitch_sw");
    rd(2'd2, 32'd0, "glitch_chg");

    // 4-clock pulse is accepted, then falls back after another debounce.
    switches = 4'b0001;
    wait_ticks(4);
    switches = 4'b0000;
    wait_ticks(2);
    rd(2'd0, 32'd1, "pulse4_sw");
    rd(2'd2, 32'd1, "pulse4_chg");
    wait_ticks(8);
    rd(2'd0, 32'd0, "pulse4_sw_fall");
    wr(2'd2, 32'h1);
    rd(2'd2, 32'd0, "pulse4_chg_clr");

    // LED path, write-only-field masking, read-only SW.
    wr(2'd1, 32'hA);
    chk("leds_write", {28'd0, LEDs}, 32'hA);
    addr  = 2'd1;
    wdata = 32'h3;
    wr_en = 1'b1;
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("rw_same_cycle", rdata, 32'hA);
    chk("leds_after_rw", {28'd0, LEDs}, 32'h3);
    rd(2'd1, 32'h3, "led_readback");
    wr(2'd1, 32'hFFFF_FFF5);
    rd(2'd1, 32'h5, "led_upper_ignored");
    wr(2'd0, 32'hF);
    rd(2'd0, 32'd0, "sw_readonly");
    wr(2'd1, 32'h3);

    // CHG / irq with MASK bit 0.
    wr(2'd3, 32'hFFFF_FFF1);
    rd(2'd3, 32'h1, "mask_readback");
    switches = 4'b0001;
    wait_ticks(6);
    chk("irq_not_early", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_rise", {31'd0, irq}, 32'd1);

    // Clear bit 0 on the same edge a falling edge is debounced: set wins.
    switches = 4'b0000;
    wait_ticks(5);
    wr(2'd2, 32'h1);
    chk("irq_at_collision", {31'd0, irq}, 32'd1);
    tick();
    chk("irq_set_wins", {31'd0, irq}, 32'd1);
    rd(2'd2, 32'h1, "chg_set_wins");
    wr(2'd2, 32'h1);
    chk("irq_clear_lag", {31'd0, irq}, 32'd1);
    tick();
    chk("irq_fall", {31'd0, irq}, 32'd0);
    rd(2'd1, 32'h3, "led_before_reset");

    // Reset two clocks into a debounce.
    switches = 4'b0001;
    wait_ticks(3);
    reset = 1'b1;
    #2;
    chk("mid_rst_leds", {28'd0, LEDs}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    addr  = 2'd0;
    rd_en = 1'b1;
    wait_ticks(6);
    chk("post_rst_sw_early", rdata, 32'd0);
    tick();
    chk("post_rst_sw_accept", rdata, 32'd1);
    rd_en = 1'b0;
    rd(2'd3, 32'd0, "post_rst_mask");
    rd(2'd2, 32'd1, "post_rst_chg");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
